waves_replay: RTL and testbench

- Synthesizable playback engine: the reading end of a waveform dump.
- Consumes a stream of change records (delta-cycle, value) produced offline from a captured trace.
- Re-drives the recorded signal on the exact cycles encoded in the stream.
- Sits between a record source (DMA/memory reader or testbench stream) and the DUT input it stimulates.

---
 rtl/waves_replay_pkg.sv | 17 +
 rtl/waves_replay_fifo.sv | 56 +++++
 rtl/waves_replay.sv | 141 ++++++++++++++
 tb/tb_waves_replay.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/waves_replay_pkg.sv
// Shared types for the waveform replay engine.
package waves_replay_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    RUN,
    STALL,
    DONE
  } replay_state_e;

  // States in which a replay is in progress and records flow.
  function automatic logic is_active(input replay_state_e s);
    return (s == PRIME) || (s == RUN) || (s == STALL);
  endfunction

endpackage

// File: rtl/waves_replay_fifo.sv
// Prefetch queue for change records: DEPTH entries, single-cycle flush,
// head presented straight from the storage registers.
module waves_replay_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             multi
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // Record storage write port.
  // NOTE: the array carries no reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign multi = (count > (AW+1)'(1));

endmodule

// File: rtl/waves_replay.sv
// Replay engine: pulls (delta, value, last) change records from a prefetch
// queue and re-drives the recorded value on the encoded cycles.
module waves_replay
  import waves_replay_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DELTA_W    = 16,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               rec_valid,
  output logic               rec_ready,
  input  logic [DELTA_W-1:0] rec_delta,
  input  logic [WIDTH-1:0]   rec_value,
  input  logic               rec_last,
  output logic [WIDTH-1:0]   sig_out,
  output logic               sig_update,
  output logic               busy,
  output logic               done,
  output logic               underrun,
  output logic [31:0]        apply_count
);

  localparam int REC_W = DELTA_W + WIDTH + 1;

  replay_state_e      state;
  replay_state_e      state_nxt;
  logic [REC_W-1:0]   head;
  logic [DELTA_W-1:0] head_delta;
  logic [WIDTH-1:0]   head_value;
  logic               head_last;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_multi;
  logic [DELTA_W:0]   timer;  // idle cycles since the last apply (or since start)
  logic               last_accepted;
  logic               active;
  logic               due;
  logic               apply;
  logic               late;
  logic               start_ok;
  logic               push;

  assign {head_delta, head_value, head_last} = head;
  assign active = is_active(state);

  // The first record also pays the PRIME capture cycle, hence the strict compare there.
  assign due      = (state == PRIME) ? (timer >  {1'b0, head_delta})
                                     : (timer >= {1'b0, head_delta});
  assign apply    = active && !abort && !fifo_empty && due;
  // A record that shows up after its slot has passed is late; the first one never counts.
  assign late     = apply && (state != PRIME) && (timer > {1'b0, head_delta});
  assign start_ok = start && !abort && ((state == IDLE) || (state == DONE));

  assign rec_ready = active && !abort && !last_accepted && (!fifo_full || apply);
  assign push      = rec_valid && rec_ready;
  assign busy      = active;
  assign done      = (state == DONE);

  waves_replay_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (abort),
    .push  (push),
    .pop   (apply),
    .wdata ({rec_delta, rec_value, rec_last}),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .multi (fifo_multi)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort overrides everything else.
  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok) state_nxt = PRIME;
      end
      PRIME, RUN, STALL: begin
        if (apply) begin
          if (head_last)       state_nxt = DONE;
          else if (fifo_multi) state_nxt = RUN;
          else                 state_nxt = STALL;
        end else if (state == STALL && !fifo_empty) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Output value, strobe, slot timer and run statistics.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sig_out       <= INIT_VALUE;
      sig_update    <= 1'b0;
      underrun      <= 1'b0;
      apply_count   <= '0;
      timer         <= '0;
      last_accepted <= 1'b0;
    end else begin
      sig_update <= apply;
      if (apply) begin
        sig_out     <= head_value;
        apply_count <= (&apply_count) ? apply_count : apply_count + 32'd1;
        timer       <= '0;
        if (late) underrun <= 1'b1;
      end else if (active && !(&timer)) begin
        timer <= timer + (DELTA_W+1)'(1);
      end
      if (push && rec_last) last_accepted <= 1'b1;
      if (start_ok) begin
        underrun      <= 1'b0;
        apply_count   <= '0;
        timer         <= '0;
        last_accepted <= 1'b0;
      end
      if (abort) begin
        timer         <= '0;
        last_accepted <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_waves_replay.sv
// Bench for waves_replay: directed tables, abort/reset sequences and random
// streams against a timeline model built from capture and apply rules.
module tb_waves_replay;

  localparam int DEPTH = 4;
  localparam int MAXR  = 16;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic        rec_valid;
  logic        rec_ready;
  logic [15:0] rec_delta;
  logic [31:0] rec_value;
  logic        rec_last;
  logic [31:0] sig_out;
  logic        sig_update;
  logic        busy;
  logic        done;
  logic        underrun;
  logic [31:0] apply_count;

  waves_replay #(
    .WIDTH      (32),
    .DELTA_W    (16),
    .DEPTH      (DEPTH),
    .INIT_VALUE (32'hDEAD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_delta   (rec_delta),
    .rec_value   (rec_value),
    .rec_last    (rec_last),
    .sig_out     (sig_out),
    .sig_update  (sig_update),
    .busy        (busy),
    .done        (done),
    .underrun    (underrun),
    .apply_count (apply_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] d;
    logic [31:0] v;
    logic        l;
    int          off;    // earliest capture edge relative to the start edge
    int          exp_t;  // expected apply edge relative to the start edge
  } vec_t;

  vec_t tbl [MAXR];

  int total;
  int bad;
  int edge_no;
  int s_edge;
  int n_src;
  int n_cap;
  int n_app;
  logic [15:0] s_d   [MAXR];
  logic [31:0] s_v   [MAXR];
  logic        s_l   [MAXR];
  int          s_off [MAXR];
  int          o_cap [MAXR];
  int          o_app [MAXR];
  logic [31:0] o_val [MAXR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample the handshake, cross the edge, log captures and applies.
  task automatic tick();
    logic fire;
    #1;
    fire = rec_valid && rec_ready;
    @(posedge clock);
    #1;
    edge_no++;
    if (fire && n_cap < MAXR) begin
      o_cap[n_cap] = edge_no - s_edge;
      n_cap++;
    end
    if (sig_update && n_app < MAXR) begin
      o_app[n_app] = edge_no - s_edge;
      o_val[n_app] = sig_out;
      n_app++;
    end
  endtask

  // Source: offer the next uncaptured record once its offer time has come.
  task automatic drive_src();
    int rel;
    rel = edge_no - s_edge;
    if (n_cap < n_src && rel >= s_off[n_cap] - 1) begin
      rec_valid = 1'b1;
      rec_delta = s_d[n_cap];
      rec_value = s_v[n_cap];
      rec_last  = s_l[n_cap];
    end else begin
      rec_valid = 1'b0;
    end
  endtask

  task automatic load_tbl(input int n);
    n_src = n;
    for (int k = 0; k < n; k++) begin
      s_d[k]   = tbl[k].d;
      s_v[k]   = tbl[k].v;
      s_l[k]   = tbl[k].l;
      s_off[k] = tbl[k].off;
    end
  endtask

  // Pulse start, then feed the stream until done (stop_apps==0) or stop_apps applies.
  task automatic run_stream(input int stop_apps, input int budget, input int poke_rel);
    n_cap  = 0;
    n_app  = 0;
    start  = 1'b1;
    s_edge = edge_no + 1;
    drive_src();
    tick();
    start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (stop_apps == 0 && done) break;
      if (stop_apps != 0 && n_app >= stop_apps) break;
      start = (edge_no - s_edge == poke_rel);
      drive_src();
      tick();
    end
    start     = 1'b0;
    rec_valid = 1'b0;
    check("run_finished", (stop_apps == 0) ? done : (n_app >= stop_apps), 1'b1);
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check_tbl(input string tag, input int n);
    check({tag, "_napp"}, n_app, n);
    for (int k = 0; k < n && k < n_app; k++) begin
      check($sformatf("%s_t%0d", tag, k), o_app[k], tbl[k].exp_t);
      check($sformatf("%s_v%0d", tag, k), o_val[k], tbl[k].v);
    end
  endtask

  // Timeline model: capture needs the offer, order and a free slot (a slot
  // frees on the edge the record DEPTH places ahead is applied); apply waits
  // for delta idle cycles after the previous apply and one cycle after capture.
  task automatic compare_model(input string tag);
    int   h [MAXR];
    int   t [MAXR];
    int   slot;
    logic und;
    und = 1'b0;
    for (int k = 0; k < n_src; k++) begin
      h[k] = imax(s_off[k], 1);
      if (k > 0)      h[k] = imax(h[k], h[k-1] + 1);
      if (k >= DEPTH) h[k] = imax(h[k], t[k-DEPTH]);
      if (k == 0) begin
        t[k] = imax(int'(s_d[k]) + 2, h[k] + 1);
      end else begin
        slot = t[k-1] + int'(s_d[k]) + 1;
        t[k] = imax(slot, h[k] + 1);
        if (h[k] + 1 > slot) und = 1'b1;
      end
    end
    check({tag, "_ncap"}, n_cap, n_src);
    check({tag, "_napp"}, n_app, n_src);
    for (int k = 0; k < n_src && k < n_app && k < n_cap; k++) begin
      check($sformatf("%s_cap%0d", tag, k), o_cap[k], h[k]);
      check($sformatf("%s_t%0d", tag, k), o_app[k], t[k]);
      check($sformatf("%s_v%0d", tag, k), o_val[k], s_v[k]);
    end
    check({tag, "_underrun"}, underrun, und);
    check({tag, "_count"}, apply_count, n_src);
    check({tag, "_done"}, done, 1'b1);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    edge_no   = 0;
    s_edge    = 0;
    n_src     = 0;
    n_cap     = 0;
    n_app     = 0;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    rec_valid = 1'b1;
    rec_delta = 16'd5;
    rec_value = 32'h1234;
    rec_last  = 1'b0;

    // Reset values, with a record already offered.
    #2;
    check("rst_sig_out", sig_out, 32'hDEAD);
    check("rst_update", sig_update, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_count", apply_count, 32'd0);
    check("rst_ready", rec_ready, 1'b0);
    #1 reset = 1'b0;
    repeat (4) tick();
    check("idle_busy", busy, 1'b0);
    check("idle_ready", rec_ready, 1'b0);
    check("idle_sig_out", sig_out, 32'hDEAD);
    rec_valid = 1'b0;

    // Basic stream: (0,A),(0,B),(3,C,last) offered continuously.
    tbl[0] = '{16'd0, 32'h0000_000A, 1'b0, 0, 2};
    tbl[1] = '{16'd0, 32'h0000_000B, 1'b0, 0, 3};
    tbl[2] = '{16'd3, 32'h0000_000C, 1'b1, 0, 7};
    load_tbl(3);
    run_stream(0, 100, -100);
    check_tbl("basic", 3);
    check("basic_done", done, 1'b1);
    check("basic_underrun", underrun, 1'b0);
    check("basic_count", apply_count, 32'd3);
    check("basic_sig_out", sig_out, 32'hC);
    rec_valid = 1'b1;
    #1;
    check("done_ready", rec_ready, 1'b0);
    rec_valid = 1'b0;

    // Same stream with C held back until 10 cycles after B is captured.
    tbl[2].off   = 12;
    tbl[2].exp_t = 13;
    load_tbl(3);
    run_stream(0, 100, -100);
    check_tbl("late", 3);
    check("late_underrun", underrun, 1'b1);
    check("late_done", done, 1'b1);

    // Abort after two applies, then restart with a fresh stream.
    tbl[2].off   = 0;
    tbl[2].exp_t = 7;
    load_tbl(3);
    run_stream(2, 100, -100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sig_out", sig_out, 32'hB);
    rec_valid = 1'b1;
    #1;
    check("abort_ready", rec_ready, 1'b0);
    rec_valid = 1'b0;
    tbl[0] = '{16'd1, 32'h0000_00D0, 1'b0, 0, 3};
    tbl[1] = '{16'd0, 32'h0000_00E0, 1'b1, 0, 4};
    load_tbl(2);
    run_stream(0, 100, -100);
    check_tbl("restart", 2);
    check("restart_count", apply_count, 32'd2);
    check("restart_underrun", underrun, 1'b0);

    // Backpressure: 8 records of delta 5 behind a 4-deep queue.
    n_src = 8;
    for (int k = 0; k < 8; k++) begin
      s_d[k]   = 16'd5;
      s_v[k]   = 32'h100 + 32'(k);
      s_l[k]   = (k == 7);
      s_off[k] = 0;
    end
    run_stream(0, 200, -100);
    compare_model("bp");

    // Asynchronous reset between edges in the middle of a run.
    run_stream(3, 200, -100);
    #2;
    reset = 1'b1;
    #1;
    check("arst_sig_out", sig_out, 32'hDEAD);
    check("arst_busy", busy, 1'b0);
    check("arst_update", sig_update, 1'b0);
    check("arst_count", apply_count, 32'd0);
    check("arst_ready", rec_ready, 1'b0);
    #2;
    reset = 1'b0;
    repeat (5) tick();
    check("arst_idle_busy", busy, 1'b0);
    check("arst_idle_update", sig_update, 1'b0);
    check("arst_idle_sig_out", sig_out, 32'hDEAD);

    // Random streams, including a start pulse mid-run that must be ignored.
    for (int it = 0; it < 8; it++) begin
      n_src = int'($urandom_range(3, 10));
      for (int k = 0; k < n_src; k++) begin
        s_d[k] = (k == 0) ? 16'd0 : 16'($urandom_range(0, 6));
        s_v[k] = $urandom;
        s_l[k] = (k == n_src - 1);
        if (k == 0 || $urandom_range(0, 1) == 0) s_off[k] = 0;
        else s_off[k] = s_off[k-1] + int'($urandom_range(0, 9));
      end
      run_stream(0, 400, int'($urandom_range(1, 12)));
      compare_model($sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
